// File: rtl/rr_stream_mux_pkg.sv
// rr_stream_mux_pkg
//   Shared helpers for the round-robin stream multiplexer.
//   next_ptr(g, n): the round-robin pointer value that follows a grant to
//   channel g in an n-channel mux. It wraps from n-1 back to 0.
//   Configuration macro RR_STREAM_MUX_FIXED_PRIO_EN is not used here. Only
//   rr_arbiter tests it.
package rr_stream_mux_pkg;

  // After channel g wins, the search starts at the channel just after g.
  // The last channel wraps back to channel 0, so N_CH need not be a power of two.
  function automatic int next_ptr(input int g, input int n);
    int nxt;
    nxt = g + 1;
    if (nxt >= n) begin
      nxt = 0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// rr_arbiter
//   Purely combinational grant logic for rr_stream_mux.
//   Ports:
//     req        in  N_CH   per-channel request (in_valid)
//     ptr        in  SEL_W  channel that has the highest priority this cycle
//     gnt_onehot out N_CH   one-hot grant, all zero when nothing requests
//     gnt_idx    out SEL_W  index of the granted channel (0 when none)
//     gnt_any    out 1      some channel is granted
//   Configuration:
//     RR_STREAM_MUX_FIXED_PRIO_EN defined   -> fixed priority, lowest index
//                                              wins and ptr is ignored
//     RR_STREAM_MUX_FIXED_PRIO_EN undefined -> round-robin scan starting at
//                                              ptr (default)
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
  // ptr has no meaning in fixed-priority mode. It is kept on the port so
  // that the top level stays identical in both builds.
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  // Scan the channels in priority order and keep only the first requester.
  // The modulo keeps idx inside 0..N_CH-1, including when N_CH is not a
  // power of two.
  always_comb begin
    logic [SEL_W-1:0] idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    idx        = '0;
    for (int k = 0; k < N_CH; k++) begin
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
      idx = SEL_W'(k);
`else
      idx = SEL_W'((int'(ptr) + k) % N_CH);
`endif
      if (!gnt_any && req[idx]) begin
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = idx;
        gnt_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   Merges N_CH valid/ready producer streams into one registered consumer
//   stream. Channels are selected round-robin. The mux never drops or
//   duplicates a beat, except that reset discards the beat held in the
//   output register.
//   Ports:
//     clk, rst   rising-edge clock. rst is an asynchronous, active-high reset.
//     in_valid   per-channel valid (N_CH)
//     in_data    channel i data at bits [i*W +: W]
//     in_ready   per-channel ready. It is combinational and at most one bit is high.
//     out_valid  registered output valid
//     out_data   registered output data (W)
//     out_sel    registered index of the channel that produced out_data
//     out_ready  consumer ready
//   Configuration: RR_STREAM_MUX_FIXED_PRIO_EN selects fixed priority
//   (lowest index wins) inside rr_arbiter. When it is undefined, the mux is
//   round-robin.
module rr_stream_mux #(
  parameter  int N_CH  = 4,
  parameter  int W     = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_sel,
  input  logic              out_ready
);

  import rr_stream_mux_pkg::*;

  logic [SEL_W-1:0] ptr;
  logic [N_CH-1:0]  gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic [W-1:0]     sel_data;

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arbiter (
    .req        (in_valid),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // The output register can accept a new beat when it is empty, or when the
  // consumer takes the current beat in this same cycle. The second case lets
  // a refill happen with no bubble.
  assign load = !out_valid || out_ready;

  // The grant is gated by rst. During reset out_valid is 0, so load is 1,
  // and without the gate a producer could see ready while the register is
  // held in reset.
  assign in_ready = (load && !rst) ? gnt_onehot : '0;

  // Select the granted channel's data. The one-hot grant gives at most one
  // match, and the result is zero when nothing is granted.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt_onehot[i]) begin
        sel_data = in_data[i*W +: W];
      end
    end
  end

  // Output register and round-robin pointer.
  // When load is 1 and nothing is valid, the register empties and ptr holds.
  // The pointer moves only when a beat is accepted, so backpressure cannot
  // skip a channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (gnt_any) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= gnt_idx;
        ptr       <= SEL_W'(next_ptr(int'(gnt_idx), N_CH));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux
//   Scoreboard bench for rr_stream_mux (N_CH=4, W=8).
//   Each channel has its own queue of source beats and presents the beat at
//   the head of that queue.
//   A reference model decides which channel must be accepted each cycle. The
//   model state is a pointer and an "output full" flag taken from the
//   scoreboard depth.
//   Each accepted beat is pushed to the scoreboard. A separate monitor
//   compares the DUT output register against the scoreboard head and pops
//   the head when the consumer takes the beat.
//   If RR_STREAM_MUX_FIXED_PRIO_EN is defined, the model uses fixed priority.
module tb_rr_stream_mux;

  localparam int N_CH  = 4;
  localparam int W     = 8;
  localparam int SEL_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH*W-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [SEL_W-1:0]  out_sel;
  logic              out_ready;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           sel;
    logic [W-1:0] data;
  } beat_t;

  beat_t        sb[$];
  logic [W-1:0] src[N_CH][$];
  int           model_ptr = 0;

  always #5 clk = ~clk;

  rr_stream_mux #(
    .N_CH (N_CH),
    .W    (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel that the specification's arbitration rule picks, or -1 when no
  // channel is valid.
  function automatic int model_grant(input logic [N_CH-1:0] v);
    int start;
    int j;
`ifdef RR_STREAM_MUX_FIXED_PRIO_EN
    start = 0;
`else
    start = model_ptr;
`endif
    for (int k = 0; k < N_CH; k++) begin
      j = (start + k) % N_CH;
      if (v[j[SEL_W-1:0]]) return j;
    end
    return -1;
  endfunction

  // One cycle of stimulus, entered just after a rising edge.
  // Modes:
  //   0 random valid / random ready
  //   1 only ch2, ready=1
  //   2 all channels, ready=1
  //   3 backpressure (ready=0)
  //   4 idle, ready=1
  //   5 ch0 and ch3, ready=1
  task automatic applyStimulus(input int mode);
    logic [N_CH-1:0] v;
    logic [N_CH-1:0] exp_rdy;
    logic            want;
    logic            load;
    int              g;
    v = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode)
        0: want = ($urandom_range(0, 1) == 1);
        1: want = (i == 2);
        2: want = 1'b1;
        3: want = ($urandom_range(0, 1) == 1);
        5: want = (i == 0) || (i == 3);
        default: want = 1'b0;
      endcase
      if (want && src[i].size() > 0) begin
        v[i]              = 1'b1;
        in_data[i*W +: W] = src[i][0];
      end else begin
        in_data[i*W +: W] = W'($urandom);
      end
    end
    in_valid = v;
    case (mode)
      0:       out_ready = ($urandom_range(0, 9) < 7);
      3:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    #1;
    load    = (sb.size() == 0) || out_ready;
    g       = model_grant(v);
    exp_rdy = '0;
    if (load && g >= 0) exp_rdy[g[SEL_W-1:0]] = 1'b1;
    checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load && g >= 0) begin
      sb.push_back('{sel: g, data: src[g][0]});
      src[g].delete(0);
      model_ptr = (g + 1) % N_CH;
    end
    #1;
  endtask

  // The monitor samples on the falling edge, away from the register update.
  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
        checkOutput("out_sel", 32'(out_sel), 32'(sb[0].sel));
        if (out_ready) sb.delete(0);
      end
    end
  end

  // Run several cycles of one mode.
  task automatic runMode(input int mode, input int cycles);
    for (int c = 0; c < cycles; c++) applyStimulus(mode);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      for (int n = 0; n < 150; n++) src[i].push_back(W'($urandom));
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_out_sel", 32'(out_sel), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;

    runMode(1, 6);
    runMode(2, 8);
    runMode(3, 5);
    runMode(2, 4);
    runMode(4, 3);
    runMode(0, 60);
    runMode(2, 3);

    // Mid-stream reset while a beat is held and every channel is valid.
    in_valid  = '1;
    out_ready = 1'b0;
    rst       = 1'b1;
    #1;
    $display("[TB] mid-stream reset, held beats dropped: %0d", sb.size());
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_out_data", 32'(out_data), 32'd0);
    checkOutput("midreset_out_sel", 32'(out_sel), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;

    runMode(2, 8);
    runMode(5, 8);
    runMode(0, 80);
    runMode(3, 5);
    runMode(4, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
